// File: rtl/barrel_shift_gen_pkg.sv
// Shared constants and helpers for the barrel_shift_gen rotator.
package barrel_shift_gen_pkg;

  localparam int ADDRESS_BITS_DEF = 3;

  function automatic int data_width(input int address_bits);
    return 1 << address_bits;
  endfunction

endpackage

// File: rtl/barrel_shift_gen_if.sv
// Data bus of the rotator: word and distance in, rotated word out.
interface barrel_shift_gen_if
  import barrel_shift_gen_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF
) ();

  localparam int W = data_width(ADDRESS_BITS);

  logic [W-1:0]            num;
  logic [ADDRESS_BITS-1:0] amt;
  logic [W-1:0]            shifted;

  modport master (output num, output amt, input shifted);
  modport slave  (input num, input amt, output shifted);

endinterface

// File: rtl/barrel_shift_gen_rotate_stage.sv
// One fixed-distance conditional rotate; passes the word through when sel is low.
module rotate_stage #(
  parameter int W    = 8,
  parameter int DIST = 1,
  parameter int LEFT = 0
) (
  input  logic [W-1:0] in,
  input  logic         sel,
  output logic [W-1:0] out
);

  logic [W-1:0] rotated;

  // DIST is always a power of two below W, so both slices are non-empty
  if (LEFT != 0) begin : g_left
    assign rotated = {in[W-DIST-1:0], in[W-1:W-DIST]};
  end else begin : g_right
    assign rotated = {in[DIST-1:0], in[W-1:DIST]};
  end

  assign out = sel ? rotated : in;

endmodule

// File: rtl/barrel_shift_gen.sv
// Registered barrel rotator: log2(W) combinational rotate stages, one output register.
module barrel_shift_gen
  import barrel_shift_gen_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int LEFT         = 0
) (
  input  logic              clk,
  input  logic              rst,
  barrel_shift_gen_if.slave bus
);

  localparam int W = data_width(ADDRESS_BITS);

  logic [W-1:0] stage_data [ADDRESS_BITS+1];
  logic [W-1:0] shifted_q;

  assign stage_data[0] = bus.num;

  // stage k contributes a rotate by 2**k, selected by amt[k]
  for (genvar k = 0; k < ADDRESS_BITS; k++) begin : g_stage
    rotate_stage #(
      .W    (W),
      .DIST (1 << k),
      .LEFT (LEFT)
    ) u_rotate_stage (
      .in  (stage_data[k]),
      .sel (bus.amt[k]),
      .out (stage_data[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shifted_q <= '0;
    end else begin
      shifted_q <= stage_data[ADDRESS_BITS];
    end
  end

  assign bus.shifted = shifted_q;

endmodule

// File: tb/tb_barrel_shift_gen.sv
// Bench for barrel_shift_gen: directed cases plus random traffic on three configurations.
module tb_barrel_shift_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  barrel_shift_gen_if #(.ADDRESS_BITS(3)) bus8l ();
  barrel_shift_gen_if #(.ADDRESS_BITS(3)) bus8r ();
  barrel_shift_gen_if #(.ADDRESS_BITS(4)) bus16l ();

  barrel_shift_gen #(.ADDRESS_BITS(3), .LEFT(1)) u_dut8l  (.clk(clk), .rst(rst), .bus(bus8l));
  barrel_shift_gen #(.ADDRESS_BITS(3), .LEFT(0)) u_dut8r  (.clk(clk), .rst(rst), .bus(bus8r));
  barrel_shift_gen #(.ADDRESS_BITS(4), .LEFT(1)) u_dut16l (.clk(clk), .rst(rst), .bus(bus16l));

  // bit i of the result takes source bit (i -/+ amt) mod w
  function automatic logic [63:0] rot_ref(input logic [63:0] num, input int amt,
                                          input int w, input bit left);
    logic [63:0] res = '0;
    for (int i = 0; i < w; i++) begin
      int src = left ? ((i - amt) % w + w) % w : (i + amt) % w;
      res[i] = num[src];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  n8l, n8r;
    logic [15:0] n16;
    int          a8l, a8r, a16;

    rst = 1'b1;
    bus8l.num = '0;  bus8l.amt = '0;
    bus8r.num = '0;  bus8r.amt = '0;
    bus16l.num = '0; bus16l.amt = '0;
    tick();
    chk("reset_8l", {56'd0, bus8l.shifted}, 64'd0);
    chk("reset_8r", {56'd0, bus8r.shifted}, 64'd0);
    chk("reset_16l", {48'd0, bus16l.shifted}, 64'd0);
    rst = 1'b0;

    // walking one, left, with amt wrapping back to 0
    for (int i = 0; i < 9; i++) begin
      bus8l.num = 8'h01;
      bus8l.amt = 3'(i % 8);
      tick();
      chk($sformatf("walk_left_amt%0d", i % 8), {56'd0, bus8l.shifted},
          64'(8'h01 << (i % 8)));
    end

    bus8r.num = 8'h01; bus8r.amt = 3'd1; tick();
    chk("right_01_a1", {56'd0, bus8r.shifted}, 64'h80);
    bus8r.amt = 3'd3; tick();
    chk("right_01_a3", {56'd0, bus8r.shifted}, 64'h20);
    bus8r.num = 8'hB4; bus8r.amt = 3'd2; tick();
    chk("right_b4_a2", {56'd0, bus8r.shifted}, 64'h2D);

    bus8l.num = 8'h81; bus8l.amt = 3'd1; tick();
    chk("left_81_a1", {56'd0, bus8l.shifted}, 64'h03);
    bus8l.amt = 3'd7; tick();
    chk("left_81_a7", {56'd0, bus8l.shifted}, 64'hC0);
    bus8l.amt = 3'd0; tick();
    chk("left_81_a0", {56'd0, bus8l.shifted}, 64'h81);

    // reset held two edges, then first free edge loads current inputs
    bus8l.num = 8'hFF; bus8l.amt = 3'd3;
    rst = 1'b1;
    tick();
    chk("rst_edge1", {56'd0, bus8l.shifted}, 64'h00);
    tick();
    chk("rst_edge2", {56'd0, bus8l.shifted}, 64'h00);
    rst = 1'b0;
    tick();
    chk("rst_release_ff", {56'd0, bus8l.shifted}, 64'hFF);

    // reset mid-stream discards the in-flight word
    bus8l.num = 8'hA5; bus8l.amt = 3'd1; rst = 1'b1;
    tick();
    chk("rst_mid", {56'd0, bus8l.shifted}, 64'h00);
    rst = 1'b0; bus8l.num = 8'h3C; bus8l.amt = 3'd1;
    tick();
    chk("rst_mid_release", {56'd0, bus8l.shifted}, 64'h78);

    bus8l.num = 8'h0F; bus8l.amt = 3'd4; tick();
    chk("b2b_first", {56'd0, bus8l.shifted}, 64'hF0);
    bus8l.num = 8'h3C; bus8l.amt = 3'd2; tick();
    chk("b2b_second", {56'd0, bus8l.shifted}, 64'hF0);

    bus16l.num = 16'h8001; bus16l.amt = 4'd15; tick();
    chk("w16_8001_a15", {48'd0, bus16l.shifted}, 64'hC000);

    for (int c = 0; c < 1000; c++) begin
      n8l = 8'($urandom);  a8l = $urandom_range(0, 7);
      n8r = 8'($urandom);  a8r = $urandom_range(0, 7);
      n16 = 16'($urandom); a16 = $urandom_range(0, 15);
      bus8l.num = n8l;  bus8l.amt = 3'(a8l);
      bus8r.num = n8r;  bus8r.amt = 3'(a8r);
      bus16l.num = n16; bus16l.amt = 4'(a16);
      tick();
      chk("rand_8l", {56'd0, bus8l.shifted}, rot_ref(64'(n8l), a8l, 8, 1'b1));
      chk("rand_8r", {56'd0, bus8r.shifted}, rot_ref(64'(n8r), a8r, 8, 1'b0));
      chk("rand_16l", {48'd0, bus16l.shifted}, rot_ref(64'(n16), a16, 16, 1'b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_shift_gen.md
BARREL_SHIFT_GEN -- requirements
Module: barrel_shift_gen

Interface
REQ-001 Parameter ADDRESS_BITS, default 3: width of amt; data width W = 2**ADDRESS_BITS (default 8).
REQ-002 Parameter LEFT, default 0: 1 = rotate left, 0 = rotate right; fixed at elaboration.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 num  input  W  data word to rotate.
REQ-006 amt  input  ADDRESS_BITS  rotate distance, unsigned, 0..W-1.
REQ-007 shifted  output  W  registered rotated result.

Function
REQ-008 The block SHALL perform a circular rotate: no bits lost, none zero-filled.
REQ-009 LEFT=1: shifted[i] SHALL equal num[(i - amt) mod W] for every i.
REQ-010 LEFT=0: shifted[i] SHALL equal num[(i + amt) mod W] for every i.
REQ-011 Latency SHALL be exactly one clock: shifted reflects the num/amt sampled at the preceding rising edge.
REQ-012 No handshake; a new num/amt SHALL be accepted every cycle (throughput 1/cycle).
REQ-013 amt=0 SHALL pass num through unchanged.
REQ-014 Every amt value 0..W-1 is legal; amt wrap (e.g. W-1 to 0) needs no special handling.
REQ-015 Rotation SHALL be built as ADDRESS_BITS cascaded combinational stages; stage k rotates by 2**k when amt[k]=1, else passes through.
REQ-016 Only the final stage output SHALL be registered; no intermediate pipeline registers.
REQ-017 The output SHALL be free of X for all known num/amt after the first clock following reset release.

Reset
REQ-018 While rst=1 at a rising edge, shifted SHALL load all zeros.
REQ-019 Reset mid-stream SHALL discard the in-flight result; the first clock with rst=0 SHALL load the rotation of the num/amt present at that edge.
REQ-020 No other state exists; no reset-release sequencing is required.

Structure
REQ-021 A shared package SHALL hold the default ADDRESS_BITS constant and a width function returning 2**ADDRESS_BITS.
REQ-022 A sub-module rotate_stage (parameters W, DIST, LEFT; ports in, sel, out) SHALL implement one fixed-distance conditional rotate.
REQ-023 Top level SHALL instantiate ADDRESS_BITS rotate_stage instances via a generate loop, followed by the output register.
REQ-024 The design SHALL elaborate for ADDRESS_BITS 1..6.

Verification
REQ-025 LEFT=1, W=8, num=8'h01, amt stepping 0..7 one step per cycle -> shifted one cycle later = 01,02,04,08,10,20,40,80; amt wraps to 0 -> 01.
REQ-026 LEFT=0, W=8, num=8'h01, amt=1 -> 80; amt=3 -> 20; num=8'hB4, amt=2 -> 2D.
REQ-027 LEFT=1, num=8'h81, amt=1 -> 03; amt=7 -> C0; amt=0 -> 81.
REQ-028 rst=1 for two edges while num=8'hFF, amt=3 -> shifted=00; rst=0 at next edge -> FF.
REQ-029 Back-to-back inputs: LEFT=1, cycle n num=8'h0F amt=4, cycle n+1 num=8'h3C amt=2 -> shifted F0 at n+1, F0 at n+2.
REQ-030 ADDRESS_BITS=4, LEFT=1, num=16'h8001, amt=15 -> C000; exhaustive random num/amt vs reference model, 1000 cycles, zero mismatches.
